// File: rtl/parametrised_register_file.sv
// Parametrised LEGv8 register file.
// Two registered read ports with a shared read-enable stall, a registered debug
// read port, write-to-read bypass, an optional hardwired-zero register, and a
// soft-clear sequencer that zeroes one register per cycle.
module parametrised_register_file #(
    parameter int DATA_WIDTH  = 64,
    parameter int ADDR_WIDTH  = 5,
    parameter int ZERO_REG    = 31,
    parameter int ZERO_REG_EN = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [ADDR_WIDTH-1:0] read_reg_address_1,
    input  logic [ADDR_WIDTH-1:0] read_reg_address_2,
    input  logic                  read_en,
    input  logic [ADDR_WIDTH-1:0] write_reg_address,
    input  logic [DATA_WIDTH-1:0] data,
    input  logic                  reg_write,
    input  logic [ADDR_WIDTH-1:0] debug_reg_address,
    input  logic                  clear_req,
    output logic [DATA_WIDTH-1:0] reg_out_1,
    output logic [DATA_WIDTH-1:0] reg_out_2,
    output logic [DATA_WIDTH-1:0] debug_out,
    output logic                  clear_busy
);

    localparam int                    DEPTH     = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR = ADDR_WIDTH'(ZERO_REG);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
    localparam logic                  ZERO_ON   = (ZERO_REG_EN != 0);

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    state_t                state;
    logic [ADDR_WIDTH-1:0] clear_cnt;
    logic                  we_eff;
    logic [DATA_WIDTH-1:0] rd_1;
    logic [DATA_WIDTH-1:0] rd_2;
    logic [DATA_WIDTH-1:0] rd_dbg;

    // Resolve one read: hardwired zero first, then same-cycle bypass, then storage.
    function automatic logic [DATA_WIDTH-1:0] resolve_read(
        input logic [ADDR_WIDTH-1:0] addr,
        input logic [DATA_WIDTH-1:0] stored,
        input logic                  we,
        input logic [ADDR_WIDTH-1:0] wr_addr,
        input logic [DATA_WIDTH-1:0] wr_data
    );
        if (ZERO_ON && (addr == ZERO_ADDR)) begin
            return '0;
        end else if (we && (wr_addr == addr)) begin
            return wr_data;
        end else begin
            return stored;
        end
    endfunction

    // Writes land only while idle, and never on the hardwired-zero register.
    // Because we_eff is low during CLEAR, the bypass is disabled there too.
    assign we_eff = reg_write && (state == IDLE)
                    && !(ZERO_ON && (write_reg_address == ZERO_ADDR));

    assign rd_1   = resolve_read(read_reg_address_1, mem[read_reg_address_1],
                                 we_eff, write_reg_address, data);
    assign rd_2   = resolve_read(read_reg_address_2, mem[read_reg_address_2],
                                 we_eff, write_reg_address, data);
    assign rd_dbg = resolve_read(debug_reg_address, mem[debug_reg_address],
                                 we_eff, write_reg_address, data);

    // Soft-clear sequencer: walks clear_cnt over every register once, then idles.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            clear_cnt  <= '0;
            clear_busy <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop
            // samples pre-edge values regardless of statement order.
            case (state)
                IDLE: begin
                    clear_cnt <= '0;
                    if (clear_req) begin
                        state      <= CLEAR;
                        clear_busy <= 1'b1;
                    end
                end
                CLEAR: begin
                    if (clear_cnt == LAST_ADDR) begin
                        state      <= IDLE;
                        clear_cnt  <= '0;
                        clear_busy <= 1'b0;
                    end else begin
                        clear_cnt <= clear_cnt + 1'b1;
                    end
                end
                default: begin
                    state      <= IDLE;
                    clear_cnt  <= '0;
                    clear_busy <= 1'b0;
                end
            endcase
        end
    end

    // Register storage: cleared by reset, by the sequencer, or written by writeback.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: the storage array is reset on purpose; the architecture requires
            // every register to read zero after reset, so this is flops, not a RAM macro.
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (state == CLEAR) begin
            mem[clear_cnt] <= '0;
        end else if (we_eff) begin
            mem[write_reg_address] <= data;
        end
    end

    // Operand read ports: update on read_en, hold during a pipeline stall.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            reg_out_1 <= '0;
            reg_out_2 <= '0;
        end else if (read_en) begin
            reg_out_1 <= rd_1;
            reg_out_2 <= rd_2;
        end
    end

    // Debug port: sampled every cycle, unaffected by stalls.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            debug_out <= '0;
        end else begin
            debug_out <= rd_dbg;
        end
    end

endmodule

// File: doc/parametrised_register_file.md
Name: parametrised_register_file

Overview:
- Next-generation register file for the LEGv8 datapath; replaces the fixed 64-bit x 32 file.
- Width, depth and the hardwired-zero register are parameters.
- Adds write-to-read bypass, a read-enable stall, a registered debug read port, and a multi-cycle soft-clear sequencer.
- Sits between decode (read addresses) and writeback (write data/address); its outputs feed the ALU operand registers.

Parameters:
DATA_WIDTH, 64, bits per register
ADDR_WIDTH, 5, address bits; DEPTH = 2**ADDR_WIDTH registers
ZERO_REG, 31, index of the hardwired-zero register (XZR)
ZERO_REG_EN, 1, 1 = ZERO_REG always reads 0 and ignores writes; 0 = ordinary register

Ports:
clk  input  1  system clock, all state on rising edge
reset_n  input  1  asynchronous, active-low reset
read_reg_address_1  input  ADDR_WIDTH  read port 1 address
read_reg_address_2  input  ADDR_WIDTH  read port 2 address
read_en  input  1  1 = update reg_out_1/2 this edge; 0 = hold (pipeline stall)
write_reg_address  input  ADDR_WIDTH  write address
data  input  DATA_WIDTH  write data
reg_write  input  1  write request
debug_reg_address  input  ADDR_WIDTH  debug read address
clear_req  input  1  one-cycle pulse starting a soft clear
reg_out_1  output  DATA_WIDTH  registered read data, port 1
reg_out_2  output  DATA_WIDTH  registered read data, port 2
debug_out  output  DATA_WIDTH  registered debug read data
clear_busy  output  1  high while the soft clear runs

Behaviour:
- Reset (reset_n=0, asynchronous):
  - all DEPTH registers, reg_out_1, reg_out_2 and debug_out go to 0 immediately.
  - FSM goes to IDLE, clear_busy=0, clear counter=0.
  - Reset asserted mid-clear aborts the clear; the result is still all-zero.
- Effective write (we_eff): reg_write=1 AND state=IDLE AND NOT (ZERO_REG_EN=1 AND write_reg_address=ZERO_REG).
  - When we_eff is true, mem[write_reg_address] <= data on the rising edge.
- Read ports, one-cycle latency:
  - On each edge with read_en=1, reg_out_k <= rd(read_reg_address_k).
  - On each edge with read_en=0, reg_out_k holds its value.
- debug_out <= rd(debug_reg_address) every edge, independent of read_en.
- rd(a) is resolved in this priority order:
  1. ZERO_REG_EN=1 and a=ZERO_REG: 0.
  2. we_eff and write_reg_address=a: data (bypass; the new value is visible in the same cycle as the write).
  3. Otherwise: mem[a].
- Both read ports and the debug port may address the same register as each other and as the write port in one cycle. All see the same rd value.
- Soft-clear FSM, states IDLE and CLEAR:
  - IDLE: clear_req=1 moves to CLEAR next edge with counter=0. Any reg_write in that same cycle is still performed.
  - CLEAR: each edge sets mem[counter] <= 0 and counter <= counter+1. When counter=DEPTH-1, return to IDLE and set counter to 0.
  - A clear occupies exactly DEPTH cycles (32 by default).
  - clear_req while in CLEAR is ignored; there is no restart and no queuing.
  - reg_write while in CLEAR is dropped.
  - Reads during CLEAR return the stored mem value with no bypass, so contents may be partially cleared. ZERO_REG still reads 0.
- clear_busy = (state==CLEAR). It is registered and rises on the edge after the clear_req edge.
- Counter is ADDR_WIDTH bits and wraps naturally. There are no X/undefined outputs after reset.

Test Plan:
- Reset then write: release reset_n; write 64'hDEAD_BEEF_0000_0001 to X6; next cycle read X6 on port 1 with read_en=1 -> reg_out_1=64'hDEAD_BEEF_0000_0001 one edge later; debug_out for address 6 shows the same value.
- Bypass: in the same cycle, reg_write=1, write_reg_address=3, data=64'h55; read_reg_address_1=3, read_reg_address_2=3 -> after that edge reg_out_1=reg_out_2=64'h55.
- XZR: write 64'hFFFF to X31 with ZERO_REG_EN=1 -> reads of 31 return 0, including the write cycle. Rebuild with ZERO_REG_EN=0 -> reads of 31 return 64'hFFFF.
- Stall: load X1=7 and X2=9, read both with read_en=1; then hold read_en=0 and change the addresses to 4/5 for 3 cycles -> outputs stay 7/9; re-assert read_en -> the new values appear after 1 edge.
- Soft clear: fill X0..X30 with nonzero values; pulse clear_req -> clear_busy is high for exactly 32 cycles. A reg_write to X4 during the clear has no effect, and a second clear_req is ignored. Afterwards all reads return 0.
- Reset mid-clear: assert reset_n=0 at clear cycle 10 -> outputs and clear_busy go to 0 immediately; after release, all registers read 0 and the FSM is in IDLE.
